// File: rtl/pixel_seq_pkg.sv
// Shared constants for the pixel readout sequencer: FSM state codes (exposed in STATUS),
// register offsets (word index = byte offset >> 2), CTRL bit positions and register reset values.
package pixel_seq_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RST  = 3'd1;
    localparam logic [2:0] ST_INT  = 3'd2;
    localparam logic [2:0] ST_XFER = 3'd3;
    localparam logic [2:0] ST_RD_A = 3'd4;
    localparam logic [2:0] ST_RD_B = 3'd5;
    localparam logic [2:0] ST_DONE = 3'd6;

    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_T_RESET = 3'd1;
    localparam logic [2:0] REG_T_INT   = 3'd2;
    localparam logic [2:0] REG_T_XFER  = 3'd3;
    localparam logic [2:0] REG_N_PIX   = 3'd4;
    localparam logic [2:0] REG_STATUS  = 3'd5;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_CONT_BIT  = 1;
    localparam int CTRL_START_BIT = 2;

    localparam logic [31:0] RST_T_RESET = 32'd4;
    localparam logic [31:0] RST_T_INT   = 32'd16;
    localparam logic [31:0] RST_T_XFER  = 32'd2;
    localparam logic [31:0] RST_N_PIX   = 32'd8;

    localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/pixel_seq_regs.sv
// Wishbone slave and register file for the pixel sequencer; single-cycle registered ack,
// writes land on the ack edge, and the CTRL start bit becomes a one-cycle start strobe.
module pixel_seq_regs
    import pixel_seq_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          CNT_W     = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_wb_cyc,
    input  logic                   i_wb_stb,
    input  logic                   i_wb_we,
    input  logic [31:0]            i_wb_addr,
    input  logic [31:0]            i_wb_data,
    output logic                   o_wb_ack,
    output logic [31:0]            o_wb_data,
    input  logic                   i_busy,
    input  logic [2:0]             i_state,
    input  logic [FRAME_CNT_W-1:0] i_frame_cnt,
    output logic                   o_en,
    output logic                   o_cont,
    output logic                   o_start,
    output logic [CNT_W-1:0]       o_t_reset,
    output logic [CNT_W-1:0]       o_t_int,
    output logic [CNT_W-1:0]       o_t_xfer,
    output logic [CNT_W-1:0]       o_n_pix
);

    logic             ack_q, ack_d;
    logic             held_q, held_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             en_q, en_d;
    logic             cont_q, cont_d;
    logic [CNT_W-1:0] t_reset_q, t_reset_d;
    logic [CNT_W-1:0] t_int_q, t_int_d;
    logic [CNT_W-1:0] t_xfer_q, t_xfer_d;
    logic [CNT_W-1:0] n_pix_q, n_pix_d;

    logic        req;
    logic        new_req;
    logic        wr;
    logic [2:0]  sel;
    logic [31:0] rd_mux;
    logic        unused_bits;

    assign req     = i_wb_cyc & i_wb_stb & (i_wb_addr[31:5] == BASE_ADDR[31:5]);
    assign sel     = i_wb_addr[4:2];
    // held_q blocks a second ack while the master keeps the same strobe asserted
    assign new_req = req & ~ack_q & ~held_q;
    assign wr      = ack_q & req & i_wb_we;

    assign unused_bits = ^{i_wb_addr[1:0], i_wb_data[31:CNT_W]};

    always_comb begin
        rd_mux = '0;
        case (sel)
            REG_CTRL:    rd_mux = {30'd0, cont_q, en_q};
            REG_T_RESET: rd_mux = {{(32-CNT_W){1'b0}}, t_reset_q};
            REG_T_INT:   rd_mux = {{(32-CNT_W){1'b0}}, t_int_q};
            REG_T_XFER:  rd_mux = {{(32-CNT_W){1'b0}}, t_xfer_q};
            REG_N_PIX:   rd_mux = {{(32-CNT_W){1'b0}}, n_pix_q};
            REG_STATUS:  rd_mux = {i_frame_cnt, 12'd0, i_state, i_busy};
            default:     rd_mux = '0;
        endcase
    end

    always_comb begin
        ack_d     = new_req;
        held_d    = (ack_q | held_q) & i_wb_cyc & i_wb_stb;
        rdata_d   = new_req ? rd_mux : '0;
        en_d      = en_q;
        cont_d    = cont_q;
        t_reset_d = t_reset_q;
        t_int_d   = t_int_q;
        t_xfer_d  = t_xfer_q;
        n_pix_d   = n_pix_q;
        if (wr) begin
            case (sel)
                REG_CTRL: begin
                    en_d   = i_wb_data[CTRL_EN_BIT];
                    cont_d = i_wb_data[CTRL_CONT_BIT];
                end
                REG_T_RESET: t_reset_d = i_wb_data[CNT_W-1:0];
                REG_T_INT:   t_int_d   = i_wb_data[CNT_W-1:0];
                REG_T_XFER:  t_xfer_d  = i_wb_data[CNT_W-1:0];
                REG_N_PIX:   n_pix_d   = i_wb_data[CNT_W-1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ack_q     <= 1'b0;
            held_q    <= 1'b0;
            rdata_q   <= '0;
            en_q      <= 1'b0;
            cont_q    <= 1'b0;
            t_reset_q <= RST_T_RESET[CNT_W-1:0];
            t_int_q   <= RST_T_INT[CNT_W-1:0];
            t_xfer_q  <= RST_T_XFER[CNT_W-1:0];
            n_pix_q   <= RST_N_PIX[CNT_W-1:0];
        end else begin
            ack_q     <= ack_d;
            held_q    <= held_d;
            rdata_q   <= rdata_d;
            en_q      <= en_d;
            cont_q    <= cont_d;
            t_reset_q <= t_reset_d;
            t_int_q   <= t_int_d;
            t_xfer_q  <= t_xfer_d;
            n_pix_q   <= n_pix_d;
        end
    end

    // The FSM sees a CTRL write on its ack cycle, so enable changes act on the same edge
    assign o_en      = en_d;
    assign o_cont    = cont_d;
    assign o_start   = wr & (sel == REG_CTRL) & i_wb_data[CTRL_START_BIT] & i_wb_data[CTRL_EN_BIT];
    assign o_wb_ack  = ack_q;
    assign o_wb_data = rdata_q;
    assign o_t_reset = t_reset_q;
    assign o_t_int   = t_int_q;
    assign o_t_xfer  = t_xfer_q;
    assign o_n_pix   = n_pix_q;

endmodule

// File: rtl/pixel_seq_ctrl.sv
// Pixel readout timing sequencer: RST -> INT -> XFER -> (RD_A, RD_B) x N -> DONE.
// All phase/strobe outputs are registered from the next state, so they switch on the entry edge.
module pixel_seq_ctrl
    import pixel_seq_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          CNT_W     = 16
) (
    input  logic        i_wb_clk,
    input  logic        i_wb_rst,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_addr,
    input  logic [31:0] i_wb_data,
    output logic        o_wb_ack,
    output logic [31:0] o_wb_data,
    output logic        o_phi_r,
    output logic        o_phi_p,
    output logic        o_phi_l1,
    output logic        o_phi_l2,
    output logic        o_adc_frame,
    output logic        o_pixel_flag,
    output logic        o_busy,
    output logic        o_frame_irq
);

    localparam logic [CNT_W-1:0] ONE = 1;

    logic             en;
    logic             cont;
    logic             start;
    logic [CNT_W-1:0] reg_t_reset;
    logic [CNT_W-1:0] reg_t_int;
    logic [CNT_W-1:0] reg_t_xfer;
    logic [CNT_W-1:0] reg_n_pix;

    logic [2:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       pix_q, pix_d;
    logic [CNT_W-1:0]       sh_t_reset_q, sh_t_reset_d;
    logic [CNT_W-1:0]       sh_t_int_q, sh_t_int_d;
    logic [CNT_W-1:0]       sh_t_xfer_q, sh_t_xfer_d;
    logic [CNT_W-1:0]       sh_n_pix_q, sh_n_pix_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic                   load;

    logic phi_r_q, phi_p_q, phi_l1_q, phi_l2_q;
    logic adc_frame_q, pixel_flag_q, busy_q, frame_irq_q;

    pixel_seq_regs #(
        .BASE_ADDR (BASE_ADDR),
        .CNT_W     (CNT_W)
    ) u_regs (
        .i_clk       (i_wb_clk),
        .i_rst       (i_wb_rst),
        .i_wb_cyc    (i_wb_cyc),
        .i_wb_stb    (i_wb_stb),
        .i_wb_we     (i_wb_we),
        .i_wb_addr   (i_wb_addr),
        .i_wb_data   (i_wb_data),
        .o_wb_ack    (o_wb_ack),
        .o_wb_data   (o_wb_data),
        .i_busy      (busy_q),
        .i_state     (state_q),
        .i_frame_cnt (frame_cnt_q),
        .o_en        (en),
        .o_cont      (cont),
        .o_start     (start),
        .o_t_reset   (reg_t_reset),
        .o_t_int     (reg_t_int),
        .o_t_xfer    (reg_t_xfer),
        .o_n_pix     (reg_n_pix)
    );

    // A programmed length of 0 still occupies one cycle
    function automatic logic [CNT_W-1:0] eff_len(input logic [CNT_W-1:0] v);
        return (v == '0) ? ONE : v;
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pix_d       = pix_q;
        frame_cnt_d = frame_cnt_q;
        load        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RST;
                    load    = 1'b1;
                end
            end
            ST_RST: begin
                if (cnt_q == sh_t_reset_q - ONE) begin
                    state_d = ST_INT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            ST_INT: begin
                if (cnt_q == sh_t_int_q - ONE) begin
                    state_d = ST_XFER;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            ST_XFER: begin
                if (cnt_q == sh_t_xfer_q - ONE) begin
                    state_d = (sh_n_pix_q == '0) ? ST_DONE : ST_RD_A;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            ST_RD_A: state_d = ST_RD_B;
            ST_RD_B: begin
                pix_d   = pix_q + ONE;
                state_d = (pix_d == sh_n_pix_q) ? ST_DONE : ST_RD_A;
            end
            ST_DONE: begin
                if (cont && en) begin
                    state_d = ST_RST;
                    load    = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            cnt_d = '0;
            pix_d = '0;
        end

        // Dropping enable aborts the frame: no DONE, so no irq and no count
        if (!en && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
        end

        if (state_d == ST_DONE && state_q != ST_DONE) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
        end
    end

    assign sh_t_reset_d = load ? eff_len(reg_t_reset) : sh_t_reset_q;
    assign sh_t_int_d   = load ? eff_len(reg_t_int)   : sh_t_int_q;
    assign sh_t_xfer_d  = load ? eff_len(reg_t_xfer)  : sh_t_xfer_q;
    assign sh_n_pix_d   = load ? reg_n_pix            : sh_n_pix_q;

    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            pix_q        <= '0;
            frame_cnt_q  <= '0;
            sh_t_reset_q <= '0;
            sh_t_int_q   <= '0;
            sh_t_xfer_q  <= '0;
            sh_n_pix_q   <= '0;
            phi_r_q      <= 1'b0;
            phi_p_q      <= 1'b0;
            phi_l1_q     <= 1'b0;
            phi_l2_q     <= 1'b0;
            adc_frame_q  <= 1'b0;
            pixel_flag_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_irq_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pix_q        <= pix_d;
            frame_cnt_q  <= frame_cnt_d;
            sh_t_reset_q <= sh_t_reset_d;
            sh_t_int_q   <= sh_t_int_d;
            sh_t_xfer_q  <= sh_t_xfer_d;
            sh_n_pix_q   <= sh_n_pix_d;
            phi_r_q      <= (state_d == ST_RST);
            phi_p_q      <= (state_d == ST_XFER);
            phi_l1_q     <= (state_d == ST_RD_A);
            phi_l2_q     <= (state_d == ST_RD_B);
            adc_frame_q  <= (state_d == ST_RD_A) || (state_d == ST_RD_B);
            pixel_flag_q <= (state_d == ST_RD_B);
            busy_q       <= (state_d != ST_IDLE);
            frame_irq_q  <= (state_d == ST_DONE);
        end
    end

    assign o_phi_r      = phi_r_q;
    assign o_phi_p      = phi_p_q;
    assign o_phi_l1     = phi_l1_q;
    assign o_phi_l2     = phi_l2_q;
    assign o_adc_frame  = adc_frame_q;
    assign o_pixel_flag = pixel_flag_q;
    assign o_busy       = busy_q;
    assign o_frame_irq  = frame_irq_q;

endmodule

// File: doc/pixel_seq_ctrl.md
Name: pixel_seq_ctrl

Overview:
Wishbone-configured timing sequencer for the pixel-sensor readout path inside designs_wrapper. It generates the phi_r / phi_p / phi_l1 / phi_l2 phase signals, the ADC frame strobe and the per-pixel flag. It runs as a frame state machine: reset, integrate, transfer, then a read scan over N pixels. Firmware programs phase lengths and the pixel count over Wishbone, then starts single-shot or continuous frames.

Parameters:
BASE_ADDR, 32'h3000_0000, Wishbone base address; decode uses bits [31:5], register select uses bits [4:2]
CNT_W, 16, width of all timing/pixel counters and registers

Ports:
i_wb_clk  in  1  sole clock
i_wb_rst  in  1  reset; asynchronous, active-high
i_wb_cyc  in  1  Wishbone cycle
i_wb_stb  in  1  Wishbone strobe
i_wb_we  in  1  write enable
i_wb_addr  in  32  byte address
i_wb_data  in  32  write data
o_wb_ack  out  1  acknowledge
o_wb_data  out  32  read data
o_phi_r  out  1  pixel reset phase
o_phi_p  out  1  charge transfer phase
o_phi_l1  out  1  readout latch 1
o_phi_l2  out  1  readout latch 2
o_adc_frame  out  1  high for the whole READ state
o_pixel_flag  out  1  one-cycle pulse per pixel, valid-sample marker
o_busy  out  1  high in any state other than IDLE
o_frame_irq  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset (async, active-high): all outputs 0; FSM = IDLE; registers at their stated reset values; frame_count = 0.
- Register map (offsets):
  - 0x00 CTRL [0] enable, [1] continuous, [2] start (write-1 pulse, reads 0). Reset 0.
  - 0x04 T_RESET, reset 4.
  - 0x08 T_INT, reset 16.
  - 0x0C T_XFER, reset 2.
  - 0x10 N_PIX, reset 8.
  - 0x14 STATUS (RO): [0] busy, [3:1] state code, [31:16] frame_count.
  - Unmapped offsets and writes outside BASE_ADDR are ignored and read 0. Registers use the low CNT_W bits.
- Wishbone:
  - o_wb_ack goes high exactly one cycle after cyc&stb&address-hit, for one cycle only. It is not reasserted while the same stb remains high after ack.
  - o_wb_data is valid with ack and 0 otherwise.
  - Writes take effect on the ack cycle. No sel handling: full word only.
- FSM states and codes: IDLE=0, RST=1, INT=2, XFER=3, RD_A=4, RD_B=5, DONE=6.
  - IDLE -> RST on start written while enable=1. On that transition T_RESET, T_INT, T_XFER and N_PIX are copied into shadow registers. Writes during a frame affect only the next frame.
  - RST: o_phi_r=1 for T_RESET cycles -> INT.
  - INT: all phases low for T_INT cycles -> XFER.
  - XFER: o_phi_p=1 for T_XFER cycles -> RD_A, or -> DONE if N_PIX=0.
  - RD_A: o_phi_l1=1 and o_adc_frame=1 for 1 cycle -> RD_B.
  - RD_B: o_phi_l2=1, o_pixel_flag=1 and o_adc_frame=1 for 1 cycle. Pixel counter increments; back to RD_A until N_PIX pixels are done, then -> DONE.
  - DONE (1 cycle): o_frame_irq=1; frame_count increments and wraps at 2^16. Then -> RST (re-shadowing registers) if continuous&enable, else -> IDLE.
- A timing value of 0 is treated as 1 cycle. Phase outputs are registered: they change on the clock edge that enters the state.
- Frame length = Tr + Ti + Tx + 2*N + 1 cycles.
- enable cleared mid-frame: FSM returns to IDLE on the next edge and all phases drop. frame_count does not increment and no irq is issued.
- start written while busy: ignored.
- Start and a clear of enable in the same write: enable wins, FSM stays in IDLE.

Decomposition:
- Shared package pixel_seq_pkg holds:
  - the state enum with the fixed codes above (STATUS exposes them);
  - register offset localparams;
  - the reset values.
- One sub-module, pixel_seq_regs, contains the Wishbone slave, the register file and the start pulse.
- The FSM and counters stay in the top level.

Test Plan:
- Reset mid-frame (assert i_wb_rst during INT) -> all outputs 0 immediately; STATUS reads 0 afterwards.
- Program T_RESET=3, T_INT=5, T_XFER=2, N_PIX=4, then write CTRL=0x5 -> phi_r high 3 cycles, 5 low cycles, phi_p high 2 cycles. Then 4 l1/l2 pairs, 4 pixel_flag pulses, adc_frame high 8 cycles, one irq; busy total 19 cycles; STATUS frame_count=1.
- N_PIX=0 and T_INT=0 -> INT lasts 1 cycle, no RD states, no adc_frame; irq one cycle after XFER ends.
- Continuous mode (CTRL=0x7) for 3 frames, then write CTRL=0x0 during RD_B of frame 3 -> frame_count=2, exactly 2 irq pulses, phases low the next cycle.
- Write T_INT=100 during INT of frame 1 (T_INT=5) -> frame 1 INT stays 5 cycles; frame 2 INT lasts 100 cycles.
- Bus checks:
  - Read an unmapped offset 0x1C -> ack after 1 cycle, data 0.
  - Access at BASE_ADDR+0x20 -> no ack.
  - Hold stb high 3 cycles -> exactly one ack pulse.
